// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four clients and the round-robin arbiter.
interface rr_arbiter4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       hold_timeout;

    // Client side: drives requests, observes grants
    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  hold_timeout
    );

    // Arbiter side: observes requests, drives grants
    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output hold_timeout
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-client round-robin arbiter with bounded grant tenure.
// A grant is held while its owner keeps requesting, for at most HOLD_MAX
// cycles; on release the owner drops to lowest priority and the next
// requester in rotation is granted on the same edge.
module rr_arbiter4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter4_if.slave  bus
);

    localparam int unsigned CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [1:0]       owner;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       gnt_q;
    logic             gnt_valid_q;
    logic             hold_timeout_q;

    logic [1:0]       search_base_c;
    logic [1:0]       winner_c;
    logic             any_req_c;
    logic             at_limit_c;
    logic             release_c;

    // First requester found scanning base, base+1, base+2, base+3 (mod 4)
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] sel;
        logic [1:0] idx;
        sel = base;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (r[idx]) begin
                sel = idx;
            end
        end
        return sel;
    endfunction

    // Search order: ptr from IDLE; a release re-searches from owner+1,
    // which is the ptr value that release installs.
    always_comb begin
        search_base_c = ptr;
        if (state == BUSY) begin
            search_base_c = owner + 2'd1;
        end
        winner_c   = pick(bus.req, search_base_c);
        any_req_c  = |bus.req;
        at_limit_c = (cnt == CNT_LAST);
        release_c  = (state == BUSY) && (!bus.req[owner] || at_limit_c);
    end

    // Arbitration state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= 2'd0;
            owner          <= 2'd0;
            cnt            <= '0;
            gnt_q          <= 4'b0000;
            gnt_valid_q    <= 1'b0;
            hold_timeout_q <= 1'b0;
        end else begin
            hold_timeout_q <= 1'b0;
            if (state == IDLE) begin
                if (any_req_c) begin
                    state       <= BUSY;
                    owner       <= winner_c;
                    cnt         <= '0;
                    gnt_q       <= 4'b0001 << winner_c;
                    gnt_valid_q <= 1'b1;
                end
            end else begin
                if (!release_c) begin
                    cnt <= cnt + CNT_W'(1);
                end else begin
                    ptr            <= owner + 2'd1;
                    hold_timeout_q <= at_limit_c && bus.req[owner];
                    if (any_req_c) begin
                        owner <= winner_c;
                        cnt   <= '0;
                        gnt_q <= 4'b0001 << winner_c;
                    end else begin
                        state       <= IDLE;
                        gnt_q       <= 4'b0000;
                        gnt_valid_q <= 1'b0;
                    end
                end
            end
        end
    end

    // Owner register doubles as the index output so it persists through IDLE
    assign bus.gnt          = gnt_q;
    assign bus.gnt_idx      = owner;
    assign bus.gnt_valid    = gnt_valid_q;
    assign bus.hold_timeout = hold_timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: three instances (HOLD_MAX 8, 4, 1) share stimulus.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_d = 4'b0000;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    rr_arbiter4_if if8 ();
    rr_arbiter4_if if4 ();
    rr_arbiter4_if if1 ();

    assign if8.req = req_d;
    assign if4.req = req_d;
    assign if1.req = req_d;

    rr_arbiter4 #(.HOLD_MAX(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    rr_arbiter4 #(.HOLD_MAX(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    rr_arbiter4 #(.HOLD_MAX(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // Behavioural reference: ten counts cycles the current owner has held
    typedef struct {
        bit       busy;
        bit [1:0] ptr;
        bit [1:0] owner;
        int       ten;
        bit       to;
    } mst_t;

    mst_t m [3];
    int   hmax [3] = '{8, 4, 1};

    function automatic bit [1:0] search(bit [3:0] q, bit [1:0] start);
        for (int k = 0; k < 4; k++) begin
            if (q[(start + k) % 4]) return 2'((start + k) % 4);
        end
        return start;
    endfunction

    function automatic mst_t mstep(mst_t s, bit r, bit [3:0] q, int h);
        mst_t n;
        n = s;
        n.to = 1'b0;
        if (r) begin
            n.busy = 1'b0; n.ptr = 2'd0; n.owner = 2'd0; n.ten = 0;
        end else if (!s.busy) begin
            if (q != 4'b0000) begin
                n.busy = 1'b1; n.owner = search(q, s.ptr); n.ten = 1;
            end
        end else if (q[s.owner] && s.ten < h) begin
            n.ten = s.ten + 1;
        end else begin
            n.to  = q[s.owner] && (s.ten == h);
            n.ptr = 2'((s.owner + 1) % 4);
            if (q != 4'b0000) begin
                n.owner = search(q, n.ptr); n.ten = 1;
            end else begin
                n.busy = 1'b0;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] pack(bit [3:0] g, bit [1:0] i, bit v, bit t);
        return {g, i, v, t};
    endfunction

    function automatic logic [7:0] mout(mst_t s);
        bit [3:0] g;
        g = s.busy ? 4'(4'b0001 << s.owner) : 4'b0000;
        return pack(g, s.owner, s.busy, s.to);
    endfunction

    function automatic logic [7:0] got(int i);
        case (i)
            0:       return {if8.gnt, if8.gnt_idx, if8.gnt_valid, if8.hold_timeout};
            1:       return {if4.gnt, if4.gnt_idx, if4.gnt_valid, if4.hold_timeout};
            default: return {if1.gnt, if1.gnt_idx, if1.gnt_valid, if1.hold_timeout};
        endcase
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got gnt=%b idx=%0d valid=%b to=%b, expected gnt=%b idx=%0d valid=%b to=%b",
                     name, $time, act[7:4], act[3:2], act[1], act[0],
                     exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // Apply one edge of stimulus, advance the model, compare all instances
    task automatic step(bit r, bit [3:0] q);
        @(negedge clk);
        rst   = r;
        req_d = q;
        @(posedge clk);
        for (int i = 0; i < 3; i++) m[i] = mstep(m[i], r, q, hmax[i]);
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("model_h%0d", hmax[i]), got(i), mout(m[i]));
    endtask

    typedef struct {
        bit       rst;
        bit [3:0] req;
        bit [3:0] gnt;
        bit [1:0] idx;
        bit       valid;
        bit       to;
    } vec_t;

    vec_t tbl [$];

    initial begin
        bit [3:0] q;
        bit [1:0] o;

        for (int i = 0; i < 3; i++) m[i] = '{1'b0, 2'd0, 2'd0, 0, 1'b0};

        // Directed table for HOLD_MAX=8
        tbl.push_back('{1, 4'b1111, 4'b0000, 2'd0, 0, 0});
        tbl.push_back('{1, 4'b1111, 4'b0000, 2'd0, 0, 0});
        tbl.push_back('{1, 4'b1111, 4'b0000, 2'd0, 0, 0});
        tbl.push_back('{0, 4'b1111, 4'b0001, 2'd0, 1, 0});
        tbl.push_back('{0, 4'b0000, 4'b0000, 2'd0, 0, 0});
        tbl.push_back('{0, 4'b0100, 4'b0100, 2'd2, 1, 0});
        tbl.push_back('{0, 4'b0100, 4'b0100, 2'd2, 1, 0});
        tbl.push_back('{0, 4'b0100, 4'b0100, 2'd2, 1, 0});
        tbl.push_back('{0, 4'b0000, 4'b0000, 2'd2, 0, 0});
        tbl.push_back('{0, 4'b0000, 4'b0000, 2'd2, 0, 0});
        tbl.push_back('{0, 4'b0010, 4'b0010, 2'd1, 1, 0});
        tbl.push_back('{0, 4'b0010, 4'b0010, 2'd1, 1, 0});
        tbl.push_back('{0, 4'b1001, 4'b1000, 2'd3, 1, 0});
        tbl.push_back('{0, 4'b0001, 4'b0001, 2'd0, 1, 0});
        tbl.push_back('{0, 4'b0000, 4'b0000, 2'd0, 0, 0});
        tbl.push_back('{0, 4'b0100, 4'b0100, 2'd2, 1, 0});
        tbl.push_back('{0, 4'b0110, 4'b0100, 2'd2, 1, 0});
        tbl.push_back('{1, 4'b0110, 4'b0000, 2'd0, 0, 0});
        tbl.push_back('{0, 4'b0110, 4'b0010, 2'd1, 1, 0});
        tbl.push_back('{0, 4'b0000, 4'b0000, 2'd1, 0, 0});

        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].req);
            chk($sformatf("table_%0d", k), got(0),
                pack(tbl[k].gnt, tbl[k].idx, tbl[k].valid, tbl[k].to));
        end

        // Full load: fixed tenure per instance, rotation 0,1,2,3 without gaps
        step(1'b1, 4'b0000);
        for (int n = 1; n <= 40; n++) begin
            step(1'b0, 4'b1111);
            o = 2'(((n - 1) / 8) % 4);
            chk("full_h8", got(0), pack(4'(4'b0001 << o), o, 1'b1, (n > 1) && ((n - 1) % 8 == 0)));
            o = 2'(((n - 1) / 4) % 4);
            chk("full_h4", got(1), pack(4'(4'b0001 << o), o, 1'b1, (n > 1) && ((n - 1) % 4 == 0)));
            o = 2'((n - 1) % 4);
            chk("full_h1", got(2), pack(4'(4'b0001 << o), o, 1'b1, n > 1));
        end

        // Lone owner: continuous grant with periodic timeout pulse
        step(1'b1, 4'b0000);
        for (int n = 1; n <= 13; n++) begin
            step(1'b0, 4'b0010);
            chk("lone_h4", got(1), pack(4'b0010, 2'd1, 1'b1, (n > 1) && ((n - 1) % 4 == 0)));
            chk("lone_h8", got(0), pack(4'b0010, 2'd1, 1'b1, (n > 1) && ((n - 1) % 8 == 0)));
        end

        // Random traffic: requests toggle sparsely, occasional reset
        q = 4'b0000;
        for (int n = 0; n < 800; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) q[b] = ~q[b];
            end
            step($urandom_range(0, 59) == 0, q);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
